float_add_pipe: RTL and testbench
=================================

// Module: float_add_pipe
// PURPOSE
//  Parametrised, fully pipelined sign/exponent/mantissa float adder/subtractor. It is the next generation of the
//  12-bit adder: generic widths, valid/ready flow control, per-operation subtract and ReLU modes, and saturation.
//  Sits in the neuron datapath between the multiplier array and the accumulator/activation stage.
// PARAMETERS
//  EXP_W  5   exponent width; bias = 2**(EXP_W-1)-1
//  MAN_W  6   stored mantissa width (hidden 1 implied); word width W = 1+EXP_W+MAN_W
// PORTS
//  clk_i       in   1  clock, rising edge
//  rst_n_i     in   1  asynchronous active-low reset
//  valid_i     in   1  operand pair valid
//  ready_o     out  1  block accepts operands this cycle
//  data_1_i    in   W  operand A {sgn, exp, man}
//  data_2_i    in   W  operand B
//  add_en_i    in   1  0: B forced to +0 (pass-through of A)
//  sub_i       in   1  1: compute A-B (B sign inverted)
//  relu_en_i   in   1  1: negative result replaced by +0
//  valid_o     out  1  result valid
//  ready_i     in   1  downstream accepts result
//  data_sum_o  out  W  result
//  status_o    out  3  {ovf, unf, zero}; only present with FADD_STATUS_EN
// BEHAVIOUR
//  - Reset (async, rst_n_i=0): all stage valids, valid_o, data_sum_o, status_o = 0; ready_o = 1 after release.
//  - Five-stage pipeline, latency 5 cycles valid_i->valid_o with no stall; throughput 1/cycle.
//  - Global advance: adv = ~valid_o | ready_i; ready_o = adv. No stage moves when adv=0 (full stall, data held).
//  - Transfer in on valid_i & ready_o; out on valid_o & ready_i. Bubbles propagate as valid=0.
//  - Mode bits (add_en_i, sub_i, relu_en_i) are captured with the operands and travel with them.
//  - Exp==0 means zero (no denormals); sign of such an input is ignored.
//  - S1: unpack, effective sign of B = sgn_b ^ sub_i; zero flags; larger exponent; |exp diff| (EXP_W+1 bits).
//  - S2: align smaller mantissa into {1,man,3 guard}; diff > MAN_W+2 -> shifted value = sticky only.
//    For effective subtract, shifted-out bits OR into the sticky LSB. Magnitude compare A>=B (exp, then man).
//  - S3: add, or larger-minus-smaller. Result sign = sign of larger magnitude. Exact cancel -> +0.
//  - S4: leading-one detect over MAN_W+5 bits; normalise; exponent adjust in EXP_W+2 signed bits.
//  - S5: round to nearest, ties away from zero (add half-LSB). Mantissa carry-out increments exponent.
//    Exponent > 2**EXP_W-1 -> saturate to max magnitude {sgn, all-ones exp, all-ones man}.
//    Exponent < 1 -> flush to +0. relu_en & negative -> +0. Zero results always have sign 0.
//  - Operands of max exponent are finite; there is no Inf/NaN encoding.
//  - Reset mid-operation discards all in-flight operands; no output for them after release.
// CONFIGURATION
//  FADD_STATUS_EN defined: status_o present, registered with data_sum_o, valid with valid_o.
//    ovf = result saturated; unf = nonzero exact result flushed to 0; zero = data_sum_o == 0.
//  Not defined: port absent, no status logic. data_sum_o timing is identical either way.
// TESTING (defaults EXP_W=5, MAN_W=6, 12-bit words)
//  1. 0x3C0 + 0x3C0, add_en=1, sub=0, ready_i=1 -> 0x400 (2.0) exactly 5 cycles after accept.
//  2. 0x3C0 with sub=1 and B=0x3C0 -> 0x000, zero status=1; 0x3E0 + 0xC00 -> 0xB80 (-0.5).
//  3. Same as 2b with relu_en=1 -> 0x000. 0x3C0 with add_en=0 and B=0x7FF -> 0x3C0.
//  4. 0x3C0 + 0x200 (tie at half LSB) -> 0x3C1. 0x7FF + 0x7FF -> 0x7FF, ovf=1.
//  5. Back-to-back 8 operands with ready_i low for 3 cycles mid-stream -> outputs stable while stalled,
//     in order, none lost or duplicated. ready_o=0 exactly while valid_o & ~ready_i.
//  6. Assert rst_n_i with 3 ops in flight -> valid_o=0 at once; after release the next op's result is correct.

Source files
------------

// File: rtl/float_add_pipe_if.sv
// Operand/result handshake bundle for float_add_pipe; W = 1+EXP_W+MAN_W.
// status_o is only present when FADD_STATUS_EN is defined.
interface float_add_pipe_if #(
    parameter int W = 12
);
    logic         valid_i;
    logic         ready_o;
    logic [W-1:0] data_1_i;
    logic [W-1:0] data_2_i;
    logic         add_en_i;
    logic         sub_i;
    logic         relu_en_i;
    logic         valid_o;
    logic         ready_i;
    logic [W-1:0] data_sum_o;
`ifdef FADD_STATUS_EN
    logic [2:0]   status_o;

    modport master (
        output valid_i, data_1_i, data_2_i, add_en_i, sub_i, relu_en_i, ready_i,
        input  ready_o, valid_o, data_sum_o, status_o
    );
    modport slave (
        input  valid_i, data_1_i, data_2_i, add_en_i, sub_i, relu_en_i, ready_i,
        output ready_o, valid_o, data_sum_o, status_o
    );
`else
    modport master (
        output valid_i, data_1_i, data_2_i, add_en_i, sub_i, relu_en_i, ready_i,
        input  ready_o, valid_o, data_sum_o
    );
    modport slave (
        input  valid_i, data_1_i, data_2_i, add_en_i, sub_i, relu_en_i, ready_i,
        output ready_o, valid_o, data_sum_o
    );
`endif
endinterface

// File: rtl/float_add_pipe.sv
// Pipelined float add/sub (hidden 1, exp==0 is zero, ties-away rounding, saturation, ReLU); FADD_STATUS_EN adds status_o.
// Latency 5 cycles from operand accept to result valid, throughput one operation per cycle.
// Backpressure: the whole pipe stalls together while a result is held (valid_o & ~ready_i); ready_o mirrors advance.
module float_add_pipe #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 6
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    float_add_pipe_if.slave bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int FW = MAN_W + 1;
    localparam int XW = MAN_W + 4;
    localparam int SW = MAN_W + 5;
    localparam int DW = EXP_W + 1;
    localparam int EW = EXP_W + 2;
    localparam int PW = $clog2(SW);
    localparam logic        [DW-1:0] SHIFT_MAX = DW'(MAN_W + 2);
    localparam logic signed [EW-1:0] EXP_TOP   = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] EXP_MIN   = EW'(1);
    localparam logic signed [EW-1:0] EXP_OFS   = EW'(MAN_W + 3);

    logic         adv;
    logic         s1_vld, s2_vld, s3_vld, s4_vld, out_vld;
    logic [W-1:0] out_dat;

    assign adv            = ~out_vld | bus.ready_i;
    assign bus.ready_o    = adv;
    assign bus.valid_o    = out_vld;
    assign bus.data_sum_o = out_dat;

    // S1: unpack; a disabled B becomes +0, zero operands lose their hidden bit
    logic [W-1:0]     b_word;
    logic [EXP_W-1:0] ea, eb;
    logic [FW-1:0]    fa, fb;
    logic [DW-1:0]    ediff;

    always_comb begin
        b_word = bus.add_en_i ? bus.data_2_i : '0;
        ea     = bus.data_1_i[W-2:MAN_W];
        eb     = b_word[W-2:MAN_W];
        fa     = (ea == '0) ? '0 : {1'b1, bus.data_1_i[MAN_W-1:0]};
        fb     = (eb == '0) ? '0 : {1'b1, b_word[MAN_W-1:0]};
        ediff  = (ea >= eb) ? (DW'(ea) - DW'(eb)) : (DW'(eb) - DW'(ea));
    end

    logic             s1_sa, s1_sb, s1_exp_gt, s1_exp_eq, s1_relu;
    logic [FW-1:0]    s1_fa, s1_fb;
    logic [EXP_W-1:0] s1_emax;
    logic [DW-1:0]    s1_diff;

    // S2: magnitude order, align the smaller operand
    logic          a_ge, eff_sub, sticky;
    logic [FW-1:0] big_f, small_f;
    logic [XW-1:0] sh_hi, sh_lo, small_x;

    always_comb begin
        a_ge           = s1_exp_gt | (s1_exp_eq & (s1_fa >= s1_fb));
        eff_sub        = s1_sa ^ s1_sb;
        big_f          = a_ge ? s1_fa : s1_fb;
        small_f        = a_ge ? s1_fb : s1_fa;
        {sh_hi, sh_lo} = {small_f, 3'b000, {XW{1'b0}}} >> s1_diff;
        sticky         = |sh_lo;
        if (s1_diff > SHIFT_MAX) begin
            sh_hi  = '0;
            sticky = |small_f;
        end
        // Sticky only matters when subtracting: it pulls a false tie below the half-LSB
        small_x = sh_hi | {{(XW-1){1'b0}}, eff_sub & sticky};
    end

    logic             s2_sub, s2_sgn, s2_relu;
    logic [XW-1:0]    s2_big, s2_small;
    logic [EXP_W-1:0] s2_emax;

    // S3: add or larger-minus-smaller
    logic [SW-1:0] sum;

    always_comb begin
        sum = s2_sub ? ({1'b0, s2_big} - {1'b0, s2_small})
                     : ({1'b0, s2_big} + {1'b0, s2_small});
    end

    logic             s3_zero, s3_sgn, s3_relu;
    logic [SW-1:0]    s3_sum;
    logic [EXP_W-1:0] s3_emax;

    // S4: leading-one detect, normalise so the leading one lands in the top bit
    logic [PW-1:0]        lod_pos, lsh;
    logic [MAN_W+1:0]     norm_hi;
    logic signed [EW-1:0] exp_adj;

    always_comb begin
        lod_pos = '0;
        for (int i = 0; i < SW; i++) begin
            if (s3_sum[i]) lod_pos = PW'(i);
        end
        lsh     = PW'(SW - 1) - lod_pos;
        norm_hi = (MAN_W+2)'((s3_sum << lsh) >> 3);
        exp_adj = EW'(s3_emax) + EW'(lod_pos) - EXP_OFS;
    end

    logic                 s4_zero, s4_sgn, s4_relu;
    logic [MAN_W+1:0]     s4_norm;
    logic signed [EW-1:0] s4_exp;

    // S5: round half away from zero, then saturate / flush / ReLU
    logic [MAN_W+1:0]     rnd;
    logic                 carry, ovf, unf, kill;
    logic [MAN_W-1:0]     man_r;
    logic signed [EW-1:0] exp_r;
    logic [W-1:0]         res;

    always_comb begin
        rnd   = {1'b0, s4_norm[MAN_W+1:1]} + (MAN_W+2)'(s4_norm[0]);
        carry = rnd[MAN_W+1];
        man_r = carry ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
        exp_r = s4_exp + EW'(carry);
        ovf   = ~s4_zero & (exp_r > EXP_TOP);
        unf   = ~s4_zero & (exp_r < EXP_MIN);
        kill  = s4_relu & s4_sgn;
        if (s4_zero | unf | kill)
            res = '0;
        else if (ovf)
            res = {s4_sgn, {(W-1){1'b1}}};
        else
            res = {s4_sgn, exp_r[EXP_W-1:0], man_r};
    end

`ifdef FADD_STATUS_EN
    logic [2:0] status_q;
    assign bus.status_o = status_q;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_vld  <= 1'b0;
            s2_vld  <= 1'b0;
            s3_vld  <= 1'b0;
            s4_vld  <= 1'b0;
            out_vld <= 1'b0;
            out_dat <= '0;
`ifdef FADD_STATUS_EN
            status_q <= '0;
`endif
        end else if (adv) begin
            s1_vld  <= bus.valid_i;
            s2_vld  <= s1_vld;
            s3_vld  <= s2_vld;
            s4_vld  <= s3_vld;
            out_vld <= s4_vld;
            if (s4_vld) begin
                out_dat <= res;
`ifdef FADD_STATUS_EN
                status_q <= {ovf & ~kill, unf, res == '0};
`endif
            end
        end
    end

    // Datapath registers carry no reset; the valid chain qualifies them
    always_ff @(posedge clk_i) begin
        if (adv) begin
            s1_sa     <= bus.data_1_i[W-1];
            s1_sb     <= b_word[W-1] ^ bus.sub_i;
            s1_fa     <= fa;
            s1_fb     <= fb;
            s1_emax   <= (ea >= eb) ? ea : eb;
            s1_exp_gt <= ea > eb;
            s1_exp_eq <= ea == eb;
            s1_diff   <= ediff;
            s1_relu   <= bus.relu_en_i;

            s2_sub    <= eff_sub;
            s2_sgn    <= a_ge ? s1_sa : s1_sb;
            s2_big    <= {big_f, 3'b000};
            s2_small  <= small_x;
            s2_emax   <= s1_emax;
            s2_relu   <= s1_relu;

            s3_sum    <= sum;
            s3_zero   <= sum == '0;
            s3_sgn    <= s2_sgn & (sum != '0);
            s3_emax   <= s2_emax;
            s3_relu   <= s2_relu;

            s4_norm   <= norm_hi;
            s4_exp    <= exp_adj;
            s4_zero   <= s3_zero;
            s4_sgn    <= s3_sgn;
            s4_relu   <= s3_relu;
        end
    end
endmodule

// File: tb/tb_float_add_pipe.sv
// Directed bench for float_add_pipe (EXP_W=5, MAN_W=6): single ops, stalled stream, reset mid-flight.
// Status bits are compared only when FADD_STATUS_EN is defined.
module tb_float_add_pipe;
    localparam int EXP_W = 5;
    localparam int MAN_W = 6;
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int NVEC  = 16;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         en;
        logic         sub;
        logic         relu;
        logic [W-1:0] want;
        logic [2:0]   st;
    } vec_t;

    logic clk_i   = 1'b0;
    logic rst_n_i = 1'b0;
    always #5 clk_i = ~clk_i;

    float_add_pipe_if #(.W(W)) bus ();

    float_add_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus.slave)
    );

    vec_t vecs [NVEC];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
        end
    endtask

    task automatic drive(input vec_t v, input logic vld);
        bus.valid_i   = vld;
        bus.data_1_i  = v.a;
        bus.data_2_i  = v.b;
        bus.add_en_i  = v.en;
        bus.sub_i     = v.sub;
        bus.relu_en_i = v.relu;
    endtask

    task automatic check_result(input string tag, input vec_t v);
        chk({tag, "_dat"}, 32'(bus.data_sum_o), 32'(v.want));
`ifdef FADD_STATUS_EN
        chk({tag, "_st"}, 32'(bus.status_o), 32'(v.st));
`endif
    endtask

    // One isolated operation: accept, measure latency, check result
    task automatic run_one(input int i);
        int k;
        @(negedge clk_i);
        drive(vecs[i], 1'b1);
        #1 chk($sformatf("v%0d_rdy", i), 32'(bus.ready_o), 32'd1);
        @(posedge clk_i);
        k = 1;
        @(negedge clk_i);
        bus.valid_i = 1'b0;
        while (!bus.valid_o && k < 20) begin
            @(posedge clk_i);
            k++;
            @(negedge clk_i);
        end
        chk($sformatf("v%0d_lat", i), 32'(k), 32'd5);
        check_result($sformatf("v%0d", i), vecs[i]);
    endtask

    initial begin
        int tx, rx, extras, stalls, k;
        logic         held_vld;
        logic [W-1:0] held;

        //          a        b        en    sub   relu  want     {ovf,unf,zero}
        vecs[0]  = '{12'h3C0, 12'h3C0, 1'b1, 1'b0, 1'b0, 12'h400, 3'b000};
        vecs[1]  = '{12'h3C0, 12'h3C0, 1'b1, 1'b1, 1'b0, 12'h000, 3'b001};
        vecs[2]  = '{12'h3E0, 12'hC00, 1'b1, 1'b0, 1'b0, 12'hB80, 3'b000};
        vecs[3]  = '{12'h3E0, 12'hC00, 1'b1, 1'b0, 1'b1, 12'h000, 3'b001};
        vecs[4]  = '{12'h3C0, 12'h7FF, 1'b0, 1'b0, 1'b0, 12'h3C0, 3'b000};
        vecs[5]  = '{12'h3C0, 12'h200, 1'b1, 1'b0, 1'b0, 12'h3C1, 3'b000};
        vecs[6]  = '{12'h7FF, 12'h7FF, 1'b1, 1'b0, 1'b0, 12'h7FF, 3'b100};
        vecs[7]  = '{12'h400, 12'h3C0, 1'b1, 1'b0, 1'b0, 12'h420, 3'b000};
        vecs[8]  = '{12'h3C0, 12'h400, 1'b1, 1'b1, 1'b0, 12'hBC0, 3'b000};
        vecs[9]  = '{12'h3C0, 12'h200, 1'b1, 1'b1, 1'b0, 12'h3BF, 3'b000};
        vecs[10] = '{12'h041, 12'h040, 1'b1, 1'b1, 1'b0, 12'h000, 3'b011};
        vecs[11] = '{12'h800, 12'h3C0, 1'b1, 1'b0, 1'b0, 12'h3C0, 3'b000};
        vecs[12] = '{12'h3FF, 12'h200, 1'b1, 1'b0, 1'b0, 12'h400, 3'b000};
        vecs[13] = '{12'hFFF, 12'hFFF, 1'b1, 1'b0, 1'b0, 12'hFFF, 3'b100};
        vecs[14] = '{12'h3C0, 12'h3C0, 1'b1, 1'b0, 1'b1, 12'h400, 3'b000};
        vecs[15] = '{12'h3C1, 12'h201, 1'b1, 1'b1, 1'b0, 12'h3C0, 3'b000};

        drive(vecs[0], 1'b0);
        bus.ready_i = 1'b1;
        rst_n_i     = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("rst_vld", 32'(bus.valid_o), 32'd0);
        chk("rst_dat", 32'(bus.data_sum_o), 32'd0);
`ifdef FADD_STATUS_EN
        chk("rst_st", 32'(bus.status_o), 32'd0);
`endif
        rst_n_i = 1'b1;
        #1 chk("rst_rdy", 32'(bus.ready_o), 32'd1);

        for (int i = 0; i < NVEC; i++) run_one(i);

        // Eight back-to-back operands, ready_i low for cycles 6..8 while results are valid
        tx = 0; rx = 0; stalls = 0;
        held_vld = 1'b0; held = '0;
        for (int cyc = 0; cyc < 100 && rx < 8; cyc++) begin
            @(negedge clk_i);
            bus.ready_i = !(cyc >= 6 && cyc < 9);
            if (tx < 8) drive(vecs[tx], 1'b1);
            else        bus.valid_i = 1'b0;
            #1;
            chk($sformatf("s%0d_rdy", cyc), 32'(bus.ready_o),
                32'(!(bus.valid_o && !bus.ready_i)));
            if (!bus.ready_o) stalls++;
            if (held_vld) begin
                chk($sformatf("s%0d_hold_vld", cyc), 32'(bus.valid_o), 32'd1);
                chk($sformatf("s%0d_hold_dat", cyc), 32'(bus.data_sum_o), 32'(held));
            end
            held_vld = bus.valid_o && !bus.ready_i;
            held     = bus.data_sum_o;
            if (bus.valid_o && bus.ready_i) begin
                chk($sformatf("s_out%0d", rx), 32'(bus.data_sum_o), 32'(vecs[rx].want));
                rx++;
            end
            if (bus.valid_i && bus.ready_o) tx++;
        end
        @(negedge clk_i);
        bus.valid_i = 1'b0;
        chk("s_rx_cnt", 32'(rx), 32'd8);
        chk("s_stall_cnt", 32'(stalls), 32'd3);
        extras = 0;
        repeat (8) begin
            @(negedge clk_i);
            if (bus.valid_o) extras++;
        end
        chk("s_extra", 32'(extras), 32'd0);

        // Three operands in flight, first one held at the output, then reset
        bus.ready_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            drive(vecs[8 + c], 1'b1);
            @(posedge clk_i);
        end
        @(negedge clk_i);
        bus.valid_i = 1'b0;
        k = 0;
        while (!bus.valid_o && k < 10) begin
            @(negedge clk_i);
            k++;
        end
        chk("r_pre_vld", 32'(bus.valid_o), 32'd1);
        chk("r_pre_dat", 32'(bus.data_sum_o), 32'(vecs[8].want));
        rst_n_i = 1'b0;
        #1;
        chk("r_vld", 32'(bus.valid_o), 32'd0);
        chk("r_dat", 32'(bus.data_sum_o), 32'd0);
        repeat (2) @(negedge clk_i);
        rst_n_i     = 1'b1;
        bus.ready_i = 1'b1;
        extras = 0;
        repeat (8) begin
            @(negedge clk_i);
            if (bus.valid_o) extras++;
        end
        chk("r_flush", 32'(extras), 32'd0);
        run_one(15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
